dot_product_sequencer: RTL and testbench

- Control FSM for the parallel dot-product datapath (PARALLEL lanes, each consuming one BUS_WIDTH-element word over BUS_WIDTH cycles).
- On start, computes all NEURONS dot products in sequence: clears the datapath, streams pixel/weight word addresses to synchronous memories, drains the multiplier/adder pipeline, and captures each result.
- Tracks the running maximum and reports the winning class. Sits between the image/weight memories and the classifier output.

---
 rtl/dot_product_sequencer.sv | 156 +++++++++++++++
 tb/tb_dot_product_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer.sv
// rtl/dot_product_sequencer.sv - control FSM that runs NEURONS dot products through the lane datapath and tracks the argmax
module dot_product_sequencer #(
    parameter int NEURONS   = 10,
    parameter int PIXEL_N   = 785,
    parameter int PARALLEL  = 4,
    parameter int BUS_WIDTH = 7,
    parameter int FPM_DELAY = 6,
    parameter int FPA_DELAY = 2,
    parameter int VAL_SIZE  = 26,
    localparam int BEATS    = (PIXEL_N + PARALLEL * BUS_WIDTH - 1) / (PARALLEL * BUS_WIDTH),
    localparam int DRAIN    = FPM_DELAY + FPA_DELAY + 4,
    localparam int PAW      = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int WAW      = $clog2(NEURONS * BEATS),
    localparam int CW       = $clog2(NEURONS)
) (
    input  logic                clk,
    input  logic                GlobalReset,
    input  logic                start,
    output logic                busy,
    output logic                dp_clear,
    output logic                bus_zero,
    output logic [PAW-1:0]      pix_addr,
    output logic [WAW-1:0]      wgt_addr,
    input  logic [VAL_SIZE-1:0] dp_value,
    output logic                result_valid,
    output logic [VAL_SIZE-1:0] result_value,
    output logic [CW-1:0]       result_neuron,
    output logic [CW-1:0]       class_out,
    output logic                done
);

    localparam int SW   = $clog2(BUS_WIDTH);
    localparam int CNTW = $clog2(DRAIN);
    localparam logic signed [VAL_SIZE-1:0] MOST_NEG = {1'b1, {(VAL_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                      state;
    logic [CW-1:0]               neuron;
    logic [PAW-1:0]              beat;
    logic [SW-1:0]               sub;
    logic [CNTW-1:0]             cnt;
    logic signed [VAL_SIZE-1:0]  max_val;

    assign dp_clear = GlobalReset || (state inside {S_IDLE, S_CLEAR, S_DONE});

    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            bus_zero      <= 1'b0;
            neuron        <= '0;
            beat          <= '0;
            sub           <= '0;
            cnt           <= '0;
            pix_addr      <= '0;
            wgt_addr      <= '0;
            max_val       <= '0;
            result_valid  <= 1'b0;
            result_value  <= '0;
            result_neuron <= '0;
            class_out     <= '0;
            done          <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            done         <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_CLEAR;
                        busy     <= 1'b1;
                        neuron   <= '0;
                        beat     <= '0;
                        sub      <= '0;
                        cnt      <= '0;
                        pix_addr <= '0;
                        wgt_addr <= '0;
                        max_val  <= MOST_NEG;
                    end
                end
                S_CLEAR: begin
                    if (cnt == CNTW'(1)) begin
                        state <= S_STREAM;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STREAM: begin
                    // Prefetch one cycle early so the next word lands as width_cnt wraps.
                    if (sub == SW'(BUS_WIDTH - 2) && beat != PAW'(BEATS - 1)) begin
                        pix_addr <= pix_addr + 1'b1;
                        wgt_addr <= wgt_addr + 1'b1;
                    end
                    if (sub == SW'(BUS_WIDTH - 1)) begin
                        sub <= '0;
                        if (beat == PAW'(BEATS - 1)) begin
                            state    <= S_DRAIN;
                            bus_zero <= 1'b1;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end else begin
                        sub <= sub + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt == CNTW'(DRAIN - 1)) begin
                        state    <= S_CAPTURE;
                        bus_zero <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    result_valid  <= 1'b1;
                    result_value  <= dp_value;
                    result_neuron <= neuron;
                    // Neuron 0 always seeds the maximum so class_out never keeps a stale winner.
                    if (neuron == '0 || $signed(dp_value) > max_val) begin
                        max_val   <= $signed(dp_value);
                        class_out <= neuron;
                    end
                    if (neuron == CW'(NEURONS - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= S_CLEAR;
                        neuron   <= neuron + 1'b1;
                        beat     <= '0;
                        pix_addr <= '0;
                        // wgt_addr parked on this neuron's last beat, so +1 is the next row base.
                        wgt_addr <= wgt_addr + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb/tb_dot_product_sequencer.sv - bench for dot_product_sequencer with memory/datapath model and argmax reference
module tb_dot_product_sequencer;

    localparam int NEURONS   = 10;
    localparam int PIXEL_N   = 785;
    localparam int PARALLEL  = 4;
    localparam int BUS_WIDTH = 7;
    localparam int BEATS     = 29;
    localparam int WORD      = PARALLEL * BUS_WIDTH;
    localparam int PADDED    = BEATS * WORD;
    localparam int PER_N     = 218;
    localparam int TOTAL     = 2181;
    localparam int DP_LAT    = 8;

    logic        clk = 1'b0;
    logic        GlobalReset;
    logic        start;
    logic        busy;
    logic        dp_clear;
    logic        bus_zero;
    logic [4:0]  pix_addr;
    logic [8:0]  wgt_addr;
    logic [25:0] dp_value;
    logic        result_valid;
    logic [25:0] result_value;
    logic [3:0]  result_neuron;
    logic [3:0]  class_out;
    logic        done;

    int errors = 0;
    int checks = 0;

    int     pix_flat [PADDED];
    int     wgt_flat [NEURONS][PADDED];
    bit     bypass_mux = 1'b0;
    int     pa_q, wa_q, wcnt;
    longint pipe [DP_LAT];
    longint acc;

    always #5 clk = ~clk;

    dot_product_sequencer dut (
        .clk          (clk),
        .GlobalReset  (GlobalReset),
        .start        (start),
        .busy         (busy),
        .dp_clear     (dp_clear),
        .bus_zero     (bus_zero),
        .pix_addr     (pix_addr),
        .wgt_addr     (wgt_addr),
        .dp_value     (dp_value),
        .result_valid (result_valid),
        .result_value (result_value),
        .result_neuron(result_neuron),
        .class_out    (class_out),
        .done         (done)
    );

    function automatic longint lane_sum(int pa, int wa, int k);
        longint s;
        int nrn, bt;
        s = 0;
        nrn = wa / BEATS;
        bt = wa % BEATS;
        if (pa >= BEATS || nrn >= NEURONS) return 0;
        for (int l = 0; l < PARALLEL; l++)
            s += longint'(pix_flat[pa*WORD + l*BUS_WIDTH + k]) * longint'(wgt_flat[nrn][bt*WORD + l*BUS_WIDTH + k]);
        return s;
    endfunction

    // Synchronous memories plus a lane datapath with a fixed pipeline delay shorter than the drain window.
    always @(posedge clk) begin
        pa_q <= int'(pix_addr);
        wa_q <= int'(wgt_addr);
        if (dp_clear) begin
            wcnt <= 0;
            acc  <= 0;
            for (int i = 0; i < DP_LAT; i++) pipe[i] <= 0;
        end else begin
            wcnt <= (wcnt == BUS_WIDTH - 1) ? 0 : wcnt + 1;
            if (!bus_zero)      pipe[0] <= lane_sum(pa_q, wa_q, wcnt);
            else if (bypass_mux) pipe[0] <= lane_sum(pa_q, wa_q, wcnt) + 5;
            else                pipe[0] <= 0;
            for (int i = 1; i < DP_LAT; i++) pipe[i] <= pipe[i-1];
            acc <= acc + pipe[DP_LAT-1];
        end
    end

    assign dp_value = acc[25:0];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < PADDED; i++) begin
            pix_flat[i] = (i < PIXEL_N) ? int'($urandom_range(3, 0)) : 0;
            for (int n = 0; n < NEURONS; n++)
                wgt_flat[n][i] = (i < PIXEL_N) ? int'($urandom_range(8, 0)) - 4 : 0;
        end
    endtask

    task automatic fill_rows(input int w[NEURONS]);
        for (int i = 0; i < PADDED; i++) begin
            pix_flat[i] = (i < PIXEL_N) ? 1 : 0;
            for (int n = 0; n < NEURONS; n++)
                wgt_flat[n][i] = (i < PIXEL_N) ? w[n] : 0;
        end
    endtask

    task automatic run_check(input string tag, input bit hold_start, input int abort_cyc);
        longint exp_val [NEURONS];
        int exp_cls;
        int busy_first = -1, clr0 = 0, bz0 = 0, bz_all = 0;
        int pchg = 0, pfirst = -1, plast = 0, pbad = 0, prev_pix = 0;
        int wfirst = -1, wmin = 1 << 20, wmax = -1;
        int rv_cnt = 0, done_cnt = 0, done_cyc = -1, cls_done = -1;
        int busy_after = -1, busy_after2 = -1;

        for (int n = 0; n < NEURONS; n++) begin
            exp_val[n] = 0;
            for (int i = 0; i < PIXEL_N; i++)
                exp_val[n] += longint'(pix_flat[i]) * longint'(wgt_flat[n][i]);
        end
        exp_cls = 0;
        for (int n = 1; n < NEURONS; n++)
            if (exp_val[n] > exp_val[exp_cls]) exp_cls = n;

        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= TOTAL + 10; c++) begin
            @(negedge clk);
            if (c == 1 && !hold_start) start = 1'b0;
            if (busy && busy_first < 0) busy_first = c;
            if (c <= PER_N) begin
                clr0 += int'(dp_clear);
                bz0  += int'(bus_zero);
                if (int'(pix_addr) != prev_pix) begin
                    pchg++;
                    if (pfirst < 0) pfirst = c;
                    else if (c - plast != BUS_WIDTH) pbad++;
                    if (int'(pix_addr) != prev_pix + 1) pbad++;
                    plast = c;
                    prev_pix = int'(pix_addr);
                end
            end
            bz_all += int'(bus_zero);
            if (c >= 3*PER_N + 1 && c <= 4*PER_N) begin
                if (wfirst < 0) wfirst = int'(wgt_addr);
                if (int'(wgt_addr) < wmin) wmin = int'(wgt_addr);
                if (int'(wgt_addr) > wmax) wmax = int'(wgt_addr);
            end
            if (result_valid) begin
                if (rv_cnt < NEURONS && abort_cyc < 0) begin
                    chk($sformatf("%s rv_cycle[%0d]", tag, rv_cnt), c, PER_N + 1 + PER_N*rv_cnt);
                    chk($sformatf("%s rv_neuron[%0d]", tag, rv_cnt), result_neuron, rv_cnt);
                    if (bypass_mux)
                        chk($sformatf("%s rv_differs[%0d]", tag, rv_cnt), $signed(result_value) != exp_val[rv_cnt], 1);
                    else
                        chk($sformatf("%s rv_value[%0d]", tag, rv_cnt), $signed(result_value), exp_val[rv_cnt]);
                end
                rv_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
                cls_done = int'(class_out);
            end
            if (c == TOTAL + 1) begin
                busy_after = int'(busy);
                start = 1'b0;
            end
            if (c == TOTAL + 2) busy_after2 = int'(busy);
            if (abort_cyc > 0 && c == abort_cyc + 1) begin
                chk({tag, " abort_busy"}, busy, 0);
                chk({tag, " abort_pix"}, pix_addr, 0);
                chk({tag, " abort_dp_clear"}, dp_clear, 1);
                GlobalReset = 1'b0;
            end
            if (abort_cyc > 0 && c == abort_cyc) GlobalReset = 1'b1;
        end

        chk({tag, " busy_first"}, busy_first, 1);
        chk({tag, " clear_cycles"}, clr0, 2);
        chk({tag, " pix_first_change"}, pfirst, 9);
        chk({tag, " pix_changes"}, pchg, BEATS - 1);
        chk({tag, " pix_step_errors"}, pbad, 0);
        chk({tag, " wgt_n3_first"}, wfirst, 3*BEATS);
        chk({tag, " wgt_n3_min"}, wmin, 87);
        chk({tag, " wgt_n3_max"}, wmax, 115);
        chk({tag, " bus_zero_n0"}, bz0, 12);
        if (abort_cyc > 0) begin
            chk({tag, " abort_results"}, rv_cnt, 4);
            chk({tag, " abort_done"}, done_cnt, 0);
        end else begin
            chk({tag, " bus_zero_all"}, bz_all, 12*NEURONS);
            chk({tag, " result_count"}, rv_cnt, NEURONS);
            chk({tag, " done_count"}, done_cnt, 1);
            chk({tag, " done_cycle"}, done_cyc, TOTAL);
            chk({tag, " busy_after_done"}, busy_after, 0);
            chk({tag, " no_restart"}, busy_after2, 0);
            if (!bypass_mux) chk({tag, " class_out"}, cls_done, exp_cls);
        end
    endtask

    initial begin
        int rows [NEURONS];
        GlobalReset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result_valid", result_valid, 0);
        chk("reset bus_zero", bus_zero, 0);
        chk("reset pix_addr", pix_addr, 0);
        chk("reset wgt_addr", wgt_addr, 0);
        chk("reset class_out", class_out, 0);
        chk("reset result_value", result_value, 0);
        chk("reset dp_clear", dp_clear, 1);
        GlobalReset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle dp_clear", dp_clear, 1);

        fill_random();
        run_check("random", 1'b0, -1);

        rows = '{3, -2, 5, 1, 0, 4, -1, 9, 2, 6};
        fill_rows(rows);
        run_check("max7_hold_start", 1'b1, -1);
        chk("max7 class", class_out, 7);

        rows = '{1, 2, 8, 3, -5, 8, 0, 7, 2, 4};
        fill_rows(rows);
        run_check("tie", 1'b0, -1);
        chk("tie class", class_out, 2);

        rows = '{-9, -4, -7, -3, -8, -6, -2, -5, -9, -4};
        fill_rows(rows);
        run_check("negative", 1'b0, -1);
        chk("negative class", class_out, 6);

        fill_random();
        bypass_mux = 1'b1;
        run_check("no_mux", 1'b0, -1);
        bypass_mux = 1'b0;

        fill_random();
        run_check("abort", 1'b0, 4*PER_N + 100);
        chk("abort class_out", class_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
